// File: rtl/btb_param_predictor_if.sv
// Fetch-side lookup and EX-side resolution signals shared by the pipeline
// (master) and the branch predictor (slave).
interface btb_param_predictor_if #(
  parameter int PC_W = 32
);
  logic            fetch_pc_valid_unused;
  logic [PC_W-1:0] fetch_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, flush, redirect_pc
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, flush, redirect_pc
  );
endinterface

// File: rtl/btb_param_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Define BTB_STATS_EN to add branch / mispredict statistics counters.
module btb_param_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memory_stall,
  btb_param_predictor_if.slave   bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, do_update;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[PC_W-1:IDX_W+2];
  assign e_idx = bus.ex_pc[IDX_W+1:2];
  assign e_tag = bus.ex_pc[PC_W-1:IDX_W+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // Registered table means the lookup naturally sees the pre-update entry.
  assign bus.pred_taken  = f_hit && cnt_q[f_idx][CNT_W-1];
  assign bus.pred_target = bus.pred_taken ? target_q[f_idx] : bus.fetch_pc + PC_W'(4);

  always_comb begin
    bus.flush       = 1'b0;
    bus.redirect_pc = '0;
    if (bus.ex_valid &&
        ((bus.ex_taken != bus.ex_pred_taken) ||
         (bus.ex_taken && bus.ex_pred_taken && (bus.ex_target != bus.ex_pred_target)))) begin
      bus.flush       = 1'b1;
      bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_W'(4);
    end
  end

  assign do_update = bus.ex_valid && !memory_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (do_update) begin
      if (e_hit) begin
        if (bus.ex_taken) begin
          target_q[e_idx] <= bus.ex_target;
          if (cnt_q[e_idx] != CNT_MAX) cnt_q[e_idx] <= cnt_q[e_idx] + CNT_W'(1);
        end else if (cnt_q[e_idx] != '0) begin
          cnt_q[e_idx] <= cnt_q[e_idx] - CNT_W'(1);
        end
      end else if (bus.ex_taken) begin
        // Only taken branches allocate; a not-taken miss already predicts correctly.
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= bus.ex_target;
        cnt_q[e_idx]    <= CNT_WT;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (do_update) begin
      stat_branches <= stat_branches + 32'd1;
      if (bus.flush) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_param_predictor.sv
// Directed vector bench for btb_param_predictor (ENTRIES=16, PC_W=32, CNT_W=2).
module tb_btb_param_predictor;
  logic clk;
  logic rst;
  logic memory_stall;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  btb_param_predictor_if #(.PC_W(32)) bus ();

  btb_param_predictor #(.ENTRIES(16), .PC_W(32), .CNT_W(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .memory_stall     (memory_stall),
    .bus              (bus.slave)
`ifdef BTB_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fpc;
    logic        ev;
    logic [31:0] epc;
    logic        etk;
    logic [31:0] etgt;
    logic        eptk;
    logic [31:0] eptgt;
    logic        stall;
    logic        x_pt;
    logic [31:0] x_ptgt;
    logic        x_fl;
    logic [31:0] x_rd;
  } vec_t;

  vec_t vecs[20];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.fetch_pc       = v.fpc;
    bus.ex_valid       = v.ev;
    bus.ex_pc          = v.epc;
    bus.ex_taken       = v.etk;
    bus.ex_target      = v.etgt;
    bus.ex_pred_taken  = v.eptk;
    bus.ex_pred_target = v.eptgt;
    memory_stall       = v.stall;
  endtask

  initial begin
    int exp_br;
    int exp_mp;
    checks = 0;
    errors = 0;
    exp_br = 0;
    exp_mp = 0;

    //            fpc           ev epc           etk etgt          eptk eptgt        st  pt ptgt          fl rd
    vecs[0]  = '{32'h40,       0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h44,       0, 32'h0};
    vecs[1]  = '{32'h40,       1, 32'h40,       1, 32'h100,      0, 32'h0,        0,  0, 32'h44,       1, 32'h100};
    vecs[2]  = '{32'h40,       1, 32'h40,       1, 32'h100,      1, 32'h100,      0,  1, 32'h100,      0, 32'h0};
    vecs[3]  = '{32'h40,       1, 32'h40,       1, 32'h100,      1, 32'h100,      0,  1, 32'h100,      0, 32'h0};
    vecs[4]  = '{32'h40,       1, 32'h40,       0, 32'h0,        1, 32'h100,      0,  1, 32'h100,      1, 32'h44};
    vecs[5]  = '{32'h40,       1, 32'h40,       0, 32'h0,        1, 32'h100,      0,  1, 32'h100,      1, 32'h44};
    vecs[6]  = '{32'h40,       0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h44,       0, 32'h0};
    vecs[7]  = '{32'h80,       0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h84,       0, 32'h0};
    vecs[8]  = '{32'h80,       1, 32'h80,       1, 32'h200,      0, 32'h0,        0,  0, 32'h84,       1, 32'h200};
    vecs[9]  = '{32'h40,       0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'h44,       0, 32'h0};
    vecs[10] = '{32'h80,       1, 32'h80,       1, 32'h300,      1, 32'h200,      0,  1, 32'h200,      1, 32'h300};
    vecs[11] = '{32'h80,       0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  1, 32'h300,      0, 32'h0};
    vecs[12] = '{32'h80,       1, 32'h80,       0, 32'h0,        1, 32'h300,      1,  1, 32'h300,      1, 32'h84};
    vecs[13] = '{32'h80,       1, 32'h80,       0, 32'h0,        1, 32'h300,      1,  1, 32'h300,      1, 32'h84};
    vecs[14] = '{32'h80,       0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  1, 32'h300,      0, 32'h0};
    vecs[15] = '{32'hC0,       1, 32'hC0,       0, 32'h0,        0, 32'h0,        0,  0, 32'hC4,       0, 32'h0};
    vecs[16] = '{32'hC0,       0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  0, 32'hC4,       0, 32'h0};
    vecs[17] = '{32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'h10,       0,  0, 32'h0,        1, 32'h0};
    vecs[18] = '{32'h84,       1, 32'h84,       1, 32'h400,      1, 32'h400,      0,  0, 32'h88,       0, 32'h0};
    vecs[19] = '{32'h84,       0, 32'h0,        0, 32'h0,        0, 32'h0,        0,  1, 32'h400,      0, 32'h0};

    rst = 1'b1;
    drive('{default: '0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef BTB_STATS_EN
    #1;
    chk("stat_branches_reset", stat_branches, 32'd0);
    chk("stat_mispredicts_reset", stat_mispredicts, 32'd0);
`endif

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("v%0d pred_taken", i),  {31'b0, bus.pred_taken}, {31'b0, vecs[i].x_pt});
      chk($sformatf("v%0d pred_target", i), bus.pred_target,         vecs[i].x_ptgt);
      chk($sformatf("v%0d flush", i),       {31'b0, bus.flush},      {31'b0, vecs[i].x_fl});
      chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc,         vecs[i].x_rd);
      if (vecs[i].ev && !vecs[i].stall) begin
        exp_br++;
        if (vecs[i].x_fl) exp_mp++;
      end
    end

    // Let the last update land, then confirm statistics against the table.
    @(negedge clk);
    drive('{default: '0});
`ifdef BTB_STATS_EN
    #1;
    chk("stat_branches", stat_branches, 32'(exp_br));
    chk("stat_mispredicts", stat_mispredicts, 32'(exp_mp));
`endif

    // Reset mid-cycle with a pending taken update: entry vanishes at once,
    // flush still tracks the EX inputs, and the update never lands.
    bus.fetch_pc       = 32'h84;
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = 32'h40;
    bus.ex_taken       = 1'b1;
    bus.ex_target      = 32'h500;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = 32'h0;
    #1;
    chk("pre_reset_hit", {31'b0, bus.pred_taken}, 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("reset_pred_target", bus.pred_target, 32'h88);
    chk("reset_flush", {31'b0, bus.flush}, 32'd1);
    chk("reset_redirect", bus.redirect_pc, 32'h500);
    @(negedge clk);
    rst = 1'b0;
    bus.ex_valid = 1'b0;
    bus.fetch_pc = 32'h40;
    #1;
    chk("post_reset_dropped_update", {31'b0, bus.pred_taken}, 32'd0);
    chk("post_reset_target", bus.pred_target, 32'h44);
`ifdef BTB_STATS_EN
    chk("post_reset_stat_branches", stat_branches, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/btb_param_predictor.md
Name: btb_param_predictor

Overview:
Parametrised branch target buffer and direction predictor for the 5-stage RISC-V pipeline. It replaces the fixed-size BTB with a table whose entry count, PC width and counter width are configurable. Each entry holds a per-entry N-bit saturating counter and a tag.
- IF side: a combinational lookup from the fetch PC.
- EX side: resolved branches update the table, and the block detects mispredictions to produce flush and redirect.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of two, 2..1024
PC_W, 32, PC width in bits
CNT_W, 2, saturating counter width, 1..4
Derived: IDX_W = log2(ENTRIES); TAG_W = PC_W - IDX_W - 2; index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
memory_stall  in  1  pipeline stall; blocks all state updates
fetch_pc  in  PC_W  IF-stage PC to predict
pred_taken  out  1  prediction for fetch_pc (combinational)
pred_target  out  PC_W  predicted target; fetch_pc+4 when pred_taken=0
ex_valid  in  1  EX-stage instruction is a resolved branch/jump
ex_pc  in  PC_W  PC of resolved branch
ex_taken  in  1  actual outcome
ex_target  in  PC_W  actual taken target
ex_pred_taken  in  1  prediction carried down the pipe with this branch
ex_pred_target  in  PC_W  predicted target carried with this branch
flush  out  1  misprediction; kill IF/ID (combinational)
redirect_pc  out  PC_W  correct next PC when flush=1, else 0

Behaviour:
- Entry state:
  - valid (1 bit), tag (TAG_W bits), target (PC_W bits), cnt (CNT_W bits).
  - WT = 1<<(CNT_W-1) (weakly taken); WNT = WT-1 (weakly not-taken).
- Reset (async, rst=1): all valid=0; cnt=WNT; tag and target=0.
  - Outputs during reset: pred_taken=0, pred_target=fetch_pc+4.
  - flush and redirect_pc follow the ex_* inputs combinationally.
  - Reset asserted mid-update: the update is discarded.
- Lookup (0 cycles, combinational):
  - hit = valid[idx] && tag[idx]==fetch tag.
  - pred_taken = hit && cnt[idx][CNT_W-1]; pred_target = pred_taken ? target[idx] : fetch_pc+4.
  - fetch_pc+4 wraps modulo 2^PC_W.
- Mispredict detection (combinational):
  - flush = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_taken && ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4; forced to 0 when flush=0.
  - flush is independent of memory_stall; the pipeline gates it.
- Update (rising edge, when ex_valid && !memory_stall):
  - Hit at ex_pc:
    - ex_taken=1: cnt = min(cnt+1, 2^CNT_W-1); target = ex_target.
    - ex_taken=0: cnt = max(cnt-1, 0); target unchanged.
  - Miss, ex_taken=1: allocate/replace. valid=1, tag=ex tag, target=ex_target, cnt=WT.
  - Miss, ex_taken=0: no change; not-taken branches never allocate.
- Simultaneous lookup and update to the same index in one cycle: lookup returns the pre-update entry (read-before-write). The new value is visible from the next cycle.
- At most one update per cycle; all other entries hold.

Optional Feature:
Macro BTB_STATS_EN.
- Defined, adds outputs:
  - stat_branches (32 bits): increments on each ex_valid && !memory_stall.
  - stat_mispredicts (32 bits): increments when, in addition, flush=1.
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold lookup: reset, fetch_pc=0x40 -> pred_taken=0, pred_target=0x44.
- First taken branch: ex_valid=1, ex_pc=0x40, ex_taken=1, ex_target=0x100, ex_pred_taken=0 -> flush=1, redirect_pc=0x100. Next cycle fetch_pc=0x40 -> pred_taken=1, pred_target=0x100.
- Hysteresis (CNT_W=2, entry at 0x40 with cnt=WT):
  - Taken x2 -> cnt=3.
  - Not-taken x1 -> still predicts taken; that update has flush=1, redirect_pc=0x44.
  - Not-taken x2 total -> cnt=1, pred_taken=0.
- Alias and target mismatch (ENTRIES=16):
  - Entry at 0x40 allocated; lookup 0x80 (same index, other tag) -> miss, pred_target=0x84.
  - Taken 0x80->0x200 replaces the 0x40 entry.
  - Predicted-taken branch with ex_target=0x300 and ex_pred_target=0x200 -> flush=1, redirect_pc=0x300.
- Stall and reset: an update with memory_stall=1 leaves the table unchanged (lookup shows the old entry). Asserting rst mid-sequence -> all lookups miss immediately.
- BTB_STATS_EN: 5 branches with 2 mispredicts, one of them issued during a stall -> stat_branches=4 (stalled update not counted); stat_mispredicts reflects only non-stalled flushes.
